// File: rtl/chaos_key_pkg.sv
// Shared definitions for the chaos-key collector: register map, STATUS layout,
// CONTROL bits and the von Neumann corrector state type.
package chaos_key_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_IRQ_EN    = 3;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_COUNT_W   = 8;

   localparam int CTRL_CLEAR  = 0;
   localparam int CTRL_IRQ_EN = 1;

   typedef enum logic {
      VN_IDLE,
      VN_PAIR
   } vn_state_t;

endpackage

// File: rtl/chaos_key_collector_if.sv
// Avalon-MM slave bus of the chaos-key collector, plus its interrupt line.
interface chaos_key_collector_if #(
   parameter int WORD_W = 32
) ();

   logic [1:0]        address;
   logic              chipselect;
   logic              read_n;
   logic              write_n;
   logic [WORD_W-1:0] writedata;
   logic [WORD_W-1:0] readdata;
   logic              irq;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/chaos_key_fifo.sv
// Single-clock key word FIFO. A pop on a full FIFO frees the slot that a
// simultaneous push then uses; clear overrides push and pop.
module chaos_key_fifo
   import chaos_key_pkg::*;
#(
   parameter  int WORD_W     = 32,
   parameter  int FIFO_DEPTH = 8,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  logic [WORD_W-1:0] i_data,
   output logic [WORD_W-1:0] o_head,
   output logic [AW:0]       o_count,
   output logic              o_empty,
   output logic              o_full
);

   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/chaos_key_collector.sv
// Debiases a raw chaotic bit stream (von Neumann), packs bits MSB-first into
// key words, buffers them in a FIFO and exposes them over Avalon-MM.
module chaos_key_collector
   import chaos_key_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_en,
   input  logic                  raw_bit,
   input  logic                  raw_valid,
   chaos_key_collector_if.slave  bus
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   vn_state_t         r_state;
   vn_state_t         w_state_nxt;
   logic              r_first;
   logic              w_emit;
   logic              w_emit_bit;
   logic [WORD_W-1:0] r_word;
   logic [CNT_W-1:0]  r_bitcnt;
   logic              w_last;
   logic              w_push;
   logic [WORD_W-1:0] w_push_word;
   logic              r_overflow;
   logic              r_irq_en;
   logic [WORD_W-1:0] r_readdata;
   logic [WORD_W-1:0] w_rdata;
   logic [WORD_W-1:0] w_status;
   logic              w_rd;
   logic              w_wr;
   logic              w_clear;
   logic              w_pop;
   logic [WORD_W-1:0] w_head;
   logic [AW:0]       w_count;
   logic              w_empty;
   logic              w_full;
   logic              w_unused_bits;

   assign w_rd    = bus.chipselect & ~bus.read_n;
   assign w_wr    = bus.chipselect & ~bus.write_n;
   assign w_clear = w_wr & (bus.address == ADDR_CONTROL) & bus.writedata[CTRL_CLEAR];
   assign w_pop   = w_rd & (bus.address == ADDR_DATA);

   always_ff @(posedge clk) begin
      if (reset) r_state <= VN_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Dropping key_en or clearing abandons any half-collected pair.
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_emit_bit  = 1'b0;
      if (!key_en || w_clear) begin
         w_state_nxt = VN_IDLE;
      end else if (raw_valid) begin
         case (r_state)
            VN_IDLE: w_state_nxt = VN_PAIR;
            VN_PAIR: begin
               w_state_nxt = VN_IDLE;
               w_emit      = r_first ^ raw_bit;
               w_emit_bit  = r_first;
            end
            default: w_state_nxt = VN_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == VN_IDLE && key_en && raw_valid) r_first <= raw_bit;
   end

   assign w_last      = (r_bitcnt == CNT_LAST);
   assign w_push      = w_emit & w_last;
   assign w_push_word = {r_word[WORD_W-2:0], w_emit_bit};

   always_ff @(posedge clk) begin
      if (reset || w_clear || !key_en) r_bitcnt <= '0;
      else if (w_emit)                 r_bitcnt <= w_last ? '0 : r_bitcnt + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (w_emit) r_word <= w_push_word;
   end

   chaos_key_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_clear),
      .i_data  (w_push_word),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // A push into a full FIFO is only lost when no pop frees a slot that cycle.
   always_ff @(posedge clk) begin
      if (reset || w_clear)                  r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop)   r_overflow <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)                                    r_irq_en <= 1'b0;
      else if (w_wr && bus.address == ADDR_CONTROL) r_irq_en <= bus.writedata[CTRL_IRQ_EN];
   end

   always_comb begin
      w_status                                   = '0;
      w_status[ST_EMPTY]                         = w_empty;
      w_status[ST_FULL]                          = w_full;
      w_status[ST_OVERFLOW]                      = r_overflow;
      w_status[ST_IRQ_EN]                        = r_irq_en;
      w_status[ST_COUNT_LSB +: ST_COUNT_W]       = ST_COUNT_W'(w_count);
   end

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         ADDR_DATA:    w_rdata = w_empty ? '0 : w_head;
         ADDR_STATUS:  w_rdata = w_status;
         ADDR_CONTROL: w_rdata[CTRL_IRQ_EN] = r_irq_en;
         default:      w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)     r_readdata <= '0;
      else if (w_rd) r_readdata <= w_rdata;
   end

   assign bus.readdata = r_readdata;
   assign bus.irq      = r_irq_en & ~w_empty;

   assign w_unused_bits = ^{bus.writedata[WORD_W-1:2], r_word[WORD_W-1]};

endmodule

// File: tb/tb_chaos_key_collector.sv
// Scoreboard bench for chaos_key_collector: reads push expected readdata into a
// queue, a monitor compares each registered read response one cycle later.
module tb_chaos_key_collector;
   import chaos_key_pkg::*;

   localparam int WORD_W     = 32;
   localparam int FIFO_DEPTH = 8;

   logic clk = 1'b0;
   logic reset;
   logic key_en;
   logic raw_bit;
   logic raw_valid;

   chaos_key_collector_if #(.WORD_W(WORD_W)) bus ();

   chaos_key_collector #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key_en    (key_en),
      .raw_bit   (raw_bit),
      .raw_valid (raw_valid),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [WORD_W-1:0] exp_q[$];
   string             name_q[$];
   int                checks = 0;
   int                errors = 0;
   logic              rd_fire_d = 1'b0;

   task automatic check(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(posedge clk) rd_fire_d <= bus.chipselect & ~bus.read_n;

   always @(negedge clk) begin
      if (rd_fire_d) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got 0x%08h, expected no response", bus.readdata);
         end else begin
            check(name_q.pop_front(), bus.readdata, exp_q.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_raw(input logic b);
      raw_bit   = b;
      raw_valid = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
   endtask

   task automatic send_pair(input logic a, input logic b);
      send_raw(a);
      send_raw(b);
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w);
      for (int i = WORD_W - 1; i >= 0; i--) send_pair(w[i], ~w[i]);
   endtask

   task automatic rd(input logic [1:0] addr, input logic [WORD_W-1:0] exp, input string nm);
      bus.address    = addr;
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.read_n     = 1'b1;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [WORD_W-1:0] data);
      bus.address    = addr;
      bus.writedata  = data;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [WORD_W-1:0] fill [9];
   logic [WORD_W-1:0] wd;

   initial begin
      reset          = 1'b1;
      key_en         = 1'b0;
      raw_bit        = 1'b0;
      raw_valid      = 1'b0;
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.read_n     = 1'b1;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      idle(3);
      reset = 1'b0;

      // Reset state
      check("rst_readdata", bus.readdata, 32'h0);
      check("rst_irq", {31'b0, bus.irq}, 32'h0);
      rd(ADDR_STATUS, 32'h0000_0001, "rst_status");
      rd(ADDR_DATA,   32'h0000_0000, "rst_data_empty");
      rd(2'd3,        32'h0000_0000, "addr3_read");

      // All-ones then all-zeros word
      key_en = 1'b1;
      for (int i = 0; i < 32; i++) send_pair(1'b1, 1'b0);
      for (int i = 0; i < 32; i++) send_pair(1'b0, 1'b1);
      rd(ADDR_STATUS, 32'h0000_0200, "t2_status_cnt2");
      rd(ADDR_DATA,   32'hFFFF_FFFF, "t2_word_ones");
      rd(ADDR_DATA,   32'h0000_0000, "t2_word_zeros");
      rd(ADDR_STATUS, 32'h0000_0001, "t2_status_empty");

      // Discarded 00/11 pairs interleaved
      for (int i = 0; i < 16; i++) begin
         send_pair(1'b0, 1'b0);
         send_pair(1'b1, 1'b0);
         send_pair(1'b1, 1'b1);
      end
      for (int i = 0; i < 16; i++) begin
         send_pair(1'b1, 1'b1);
         send_pair(1'b0, 1'b1);
         send_pair(1'b0, 1'b0);
      end
      rd(ADDR_STATUS, 32'h0000_0100, "t3_status_cnt1");
      rd(ADDR_DATA,   32'hFFFF_0000, "t3_word");
      rd(ADDR_STATUS, 32'h0000_0001, "t3_status_empty");

      // Fill, overflow, drain in order, clear
      for (int k = 0; k < 9; k++) fill[k] = 32'h1357_0000 ^ (32'h0101_0101 * (k + 1)) ^ (32'h8000_0000 >> k);
      for (int k = 0; k < 9; k++) send_word(fill[k]);
      rd(ADDR_STATUS, 32'h0000_0806, "t4_status_full_ovf");
      for (int k = 0; k < 8; k++) rd(ADDR_DATA, fill[k], $sformatf("t4_word%0d", k));
      rd(ADDR_STATUS, 32'h0000_0005, "t4_status_ovf_sticky");
      wr(ADDR_CONTROL, 32'h0000_0001);
      rd(ADDR_STATUS, 32'h0000_0001, "t4_status_cleared");

      // Aborted word: 20 zero bits plus half a pair, then key_en low
      for (int i = 0; i < 20; i++) send_pair(1'b0, 1'b1);
      send_raw(1'b1);
      key_en = 1'b0;
      send_raw(1'b0);
      send_raw(1'b1);
      key_en = 1'b1;
      for (int i = 0; i < 32; i++) send_pair(1'b1, 1'b0);
      rd(ADDR_STATUS, 32'h0000_0100, "t5_status_cnt1");
      rd(ADDR_DATA,   32'hFFFF_FFFF, "t5_word");
      rd(ADDR_STATUS, 32'h0000_0001, "t5_status_empty");

      // Interrupt, pop coinciding with push, drain
      send_word(32'hA5A5_0001);
      send_word(32'h1234_5678);
      send_word(32'h0F0F_F0F0);
      wr(ADDR_CONTROL, 32'h0000_0002);
      check("t6_irq_high", {31'b0, bus.irq}, 32'h1);
      rd(ADDR_STATUS,  32'h0000_0308, "t6_status_cnt3_irqen");
      rd(ADDR_CONTROL, 32'h0000_0002, "t6_control_read");
      wd = 32'hCAFE_BABE;
      for (int i = WORD_W - 1; i >= 1; i--) send_pair(wd[i], ~wd[i]);
      send_raw(wd[0]);
      raw_bit        = ~wd[0];
      raw_valid      = 1'b1;
      bus.address    = ADDR_DATA;
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      exp_q.push_back(32'hA5A5_0001);
      name_q.push_back("t6_pop_with_push");
      @(posedge clk);
      #1;
      raw_valid      = 1'b0;
      bus.chipselect = 1'b0;
      bus.read_n     = 1'b1;
      rd(ADDR_STATUS, 32'h0000_0308, "t6_status_cnt_kept");
      wr(ADDR_STATUS, 32'hFFFF_FFFF);
      wr(2'd3,        32'hFFFF_FFFF);
      rd(ADDR_STATUS, 32'h0000_0308, "t6_ignored_writes");
      rd(ADDR_DATA, 32'h1234_5678, "t6_word_b");
      rd(ADDR_DATA, 32'h0F0F_F0F0, "t6_word_c");
      check("t6_irq_before_last", {31'b0, bus.irq}, 32'h1);
      rd(ADDR_DATA, 32'hCAFE_BABE, "t6_word_d");
      check("t6_irq_after_last", {31'b0, bus.irq}, 32'h0);
      rd(ADDR_STATUS, 32'h0000_0009, "t6_status_empty_irqen");
      rd(ADDR_DATA,   32'h0000_0000, "t6_data_empty");

      idle(3);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
